// File: rtl/fpdot_seq_ctrl_pkg.sv
// Shared types and constants for the streaming dot-product sequencer
// and its lane-mask helper.
package fpdot_seq_ctrl_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LANES = 9;

  localparam logic [WIDTH-1:0] FP_POS_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    if (value > 1) begin
      for (v = value - 1; v > 0; v = v >> 1) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fpdot_lane_mask.sv
// Zeroes A and B in every lane at or beyond the count of element pairs
// still owed to the job, so the padding lanes contribute +0.0 products.
module fpdot_lane_mask #(
  parameter int unsigned WIDTH = fpdot_seq_ctrl_pkg::WIDTH,
  parameter int unsigned LANES = fpdot_seq_ctrl_pkg::LANES,
  parameter int unsigned LEN_W = 10
) (
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LEN_W-1:0]       remaining,
  output logic [LANES*WIDTH-1:0] a_masked,
  output logic [LANES*WIDTH-1:0] b_masked
);
  import fpdot_seq_ctrl_pkg::*;

  always_comb begin
    a_masked = a;
    b_masked = b;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (k >= 32'(remaining)) begin
        a_masked[k*WIDTH +: WIDTH] = WIDTH'(FP_POS_ZERO);
        b_masked[k*WIDTH +: WIDTH] = WIDTH'(FP_POS_ZERO);
      end
    end
  end

endmodule

// File: rtl/fpdot_seq_ctrl.sv
// Sequencer that feeds a runtime-length dot product, chunk by chunk, through a
// fixed LANES-wide FMA pipeline, carrying the running sum as the addend.
module fpdot_seq_ctrl #(
  parameter int unsigned WIDTH    = fpdot_seq_ctrl_pkg::WIDTH,
  parameter int unsigned LANES    = fpdot_seq_ctrl_pkg::LANES,
  parameter int unsigned MAX_LEN  = 1023,
  parameter int unsigned LEN_W    = fpdot_seq_ctrl_pkg::clog2(MAX_LEN + 1),
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [LEN_W-1:0]       job_len,
  input  logic [WIDTH-1:0]       job_c,
  input  logic                   elem_valid,
  output logic                   elem_ready,
  input  logic [LANES*WIDTH-1:0] elem_a,
  input  logic [LANES*WIDTH-1:0] elem_b,
  output logic [LANES*WIDTH-1:0] fma_a,
  output logic [LANES*WIDTH-1:0] fma_b,
  output logic [WIDTH-1:0]       fma_c,
  output logic                   fma_issue,
  input  logic [WIDTH-1:0]       fma_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   busy
);
  import fpdot_seq_ctrl_pkg::*;

  localparam int unsigned CNT_W = clog2(PIPE_LAT + 2);

  state_t                   state;
  logic [WIDTH-1:0]         acc;
  logic [LEN_W-1:0]         remaining;
  logic [CNT_W-1:0]         cnt;
  logic [LEN_W-1:0]         len_sat;
  logic [LANES*WIDTH-1:0]   a_masked;
  logic [LANES*WIDTH-1:0]   b_masked;

  assign len_sat    = (32'(job_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : job_len;
  assign job_ready  = (state == IDLE);
  assign elem_ready = (state == ISSUE);
  assign busy       = (state != IDLE);

  fpdot_lane_mask #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .LEN_W (LEN_W)
  ) u_lane_mask (
    .a         (elem_a),
    .b         (elem_b),
    .remaining (remaining),
    .a_masked  (a_masked),
    .b_masked  (b_masked)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      cnt       <= '0;
      fma_a     <= '0;
      fma_b     <= '0;
      fma_c     <= '0;
      fma_issue <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      fma_issue <= 1'b0;
      unique case (state)
        IDLE: begin
          if (job_valid) begin
            acc       <= job_c;
            remaining <= len_sat;
            if (len_sat != '0) begin
              state <= ISSUE;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= job_c;
            end
          end
        end
        ISSUE: begin
          if (elem_valid) begin
            fma_a     <= a_masked;
            fma_b     <= b_masked;
            fma_c     <= acc;
            fma_issue <= 1'b1;
            cnt       <= '0;
            remaining <= (remaining < LEN_W'(LANES)) ? '0 : remaining - LEN_W'(LANES);
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(PIPE_LAT)) begin
            acc <= fma_result;
            // res_data is loaded straight from the pipeline so it is valid
            // in the same cycle res_valid rises.
            if (remaining == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_data  <= fma_result;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpdot_seq_ctrl.sv
// Self-checking bench for fpdot_seq_ctrl: models the FMA pipeline as the
// environment and checks each job against a flat sum-of-products reference.
module tb_fpdot_seq_ctrl;
  localparam int W  = 32;
  localparam int L  = 9;
  localparam int ML = 1023;
  localparam int LW = 10;
  localparam int PL = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           job_valid = 1'b0;
  logic           job_ready;
  logic [LW-1:0]  job_len = '0;
  logic [W-1:0]   job_c = '0;
  logic           elem_valid = 1'b0;
  logic           elem_ready;
  logic [L*W-1:0] elem_a = '0;
  logic [L*W-1:0] elem_b = '0;
  logic [L*W-1:0] fma_a;
  logic [L*W-1:0] fma_b;
  logic [W-1:0]   fma_c;
  logic           fma_issue;
  logic [W-1:0]   fma_result;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [W-1:0]   res_data;
  logic           busy;

  fpdot_seq_ctrl #(
    .WIDTH    (W),
    .LANES    (L),
    .MAX_LEN  (ML),
    .LEN_W    (LW),
    .PIPE_LAT (PL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_len    (job_len),
    .job_c      (job_c),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_a     (elem_a),
    .elem_b     (elem_b),
    .fma_a      (fma_a),
    .fma_b      (fma_b),
    .fma_c      (fma_c),
    .fma_issue  (fma_issue),
    .fma_result (fma_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int issue_cnt = 0;
  int issue_cyc[$];
  logic [L*W-1:0] last_fa, last_fb;
  logic [W-1:0] a_mem [0:ML+L];
  logic [W-1:0] b_mem [0:ML+L];
  bit junk_elem = 0;

  // IEEE single <-> double conversions (denormals flushed to zero)
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [7:0]  e;
    e = x[30:23];
    if (e == 8'h00)      d = {x[31], 63'b0};
    else if (e == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'b0};
    else                 d = {x[31], 11'(e) + 11'd896, x[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    int e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e == 0)    return {d[63], 31'b0};
    if (e == 2047) return {d[63], 8'hFF, d[51:29]};
    e = e - 896;
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [W-1:0] lane(input logic [L*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  // Values chosen so every partial sum stays exact in single precision
  function automatic logic [31:0] rand_val();
    logic [31:0] tbl [0:6];
    tbl[0] = 32'h3F800000; tbl[1] = 32'h40000000; tbl[2] = 32'hBF800000;
    tbl[3] = 32'h3F000000; tbl[4] = 32'hC0000000; tbl[5] = 32'h40400000;
    tbl[6] = 32'hBF000000;
    return tbl[$urandom_range(0, 6)];
  endfunction

  // Environment: the LANES-way dot-product FMA pipeline, PL cycles deep
  function automatic logic [W-1:0] pipe_calc(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                             input logic [W-1:0] c);
    real s;
    s = sp2r(c);
    for (int k = 0; k < L; k++) s = s + sp2r(a[k*W +: W]) * sp2r(b[k*W +: W]);
    return r2sp(s);
  endfunction

  logic [W-1:0] pipe [0:PL-1];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= fma_issue ? pipe_calc(fma_a, fma_b, fma_c) : 32'hDEADBEEF;
      for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign fma_result = pipe[PL-1];

  always @(posedge clk) begin
    if (rst && fma_issue) begin
      issue_cnt = issue_cnt + 1;
      issue_cyc.push_back(cyc);
      last_fa = fma_a;
      last_fb = fma_b;
    end
    cyc = cyc + 1;
  end

  // Reference: c + sum of A[i]*B[i] over the (saturated) job length
  function automatic logic [W-1:0] ref_dot(input int len, input logic [W-1:0] c);
    real s;
    int n;
    n = (len > ML) ? ML : len;
    s = sp2r(c);
    for (int i = 0; i < n; i++) s = s + sp2r(a_mem[i]) * sp2r(b_mem[i]);
    return r2sp(s);
  endfunction

  function automatic int ref_lat(input int len);
    return (len == 0) ? 1 : 1 + ((len + L - 1) / L) * (PL + 2);
  endfunction

  task automatic fill_const(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = 0; i <= ML + L; i++) begin a_mem[i] = av; b_mem[i] = bv; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i <= ML + L; i++) begin a_mem[i] = rand_val(); b_mem[i] = rand_val(); end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Drives one job and its chunks; returns when res_valid is seen, the
  // cycle budget runs out, or stop_after issues have happened.
  task automatic run_job(input int len, input logic [W-1:0] c, input bit poison, input int stop_after,
                         output logic [W-1:0] data, output int lat, output int n_issue, output bit tmo);
    int t0, base, chunk, budget, idx;
    tmo = 0; data = '0; lat = -1; n_issue = 0;
    budget = 40;
    while (!job_ready && budget > 0) begin @(negedge clk); budget--; end
    if (!job_ready) begin tmo = 1; return; end
    job_valid = 1'b1; job_len = LW'(len); job_c = c;
    t0 = cyc; base = issue_cnt; chunk = 0;
    @(negedge clk);
    job_valid = 1'b0; job_len = LW'($urandom); job_c = $urandom;
    budget = (len / L + 2) * (PL + 2) + 20;
    while (!res_valid && budget > 0) begin
      if (stop_after > 0 && issue_cnt - base >= stop_after) break;
      if (elem_ready) begin
        for (int k = 0; k < L; k++) begin
          idx = chunk * L + k;
          if (idx < len) begin
            elem_a[k*W +: W] = a_mem[idx];
            elem_b[k*W +: W] = b_mem[idx];
          end else begin
            elem_a[k*W +: W] = poison ? 32'h7F800000 : rand_val();
            elem_b[k*W +: W] = poison ? 32'h7F800000 : rand_val();
          end
        end
        elem_valid = 1'b1;
        chunk++;
      end else begin
        elem_valid = junk_elem;
        for (int k = 0; k < L; k++) begin
          elem_a[k*W +: W] = $urandom;
          elem_b[k*W +: W] = $urandom;
        end
      end
      @(negedge clk);
      budget--;
    end
    elem_valid = 1'b0;
    n_issue = issue_cnt - base;
    if (res_valid) begin
      data = res_data;
      lat = cyc - t0;
    end else if (stop_after == 0) begin
      tmo = 1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (fma_issue !== 1'b0) $display("FAIL reset_fma_issue: got %b want 0", fma_issue); else passed++;
    total++; if (res_data !== '0) $display("FAIL reset_res_data: got %h want 0", res_data); else passed++;
    total++; if (fma_c !== '0 || fma_a !== '0 || fma_b !== '0)
      $display("FAIL reset_fma_operands: got c=%h want 0", fma_c); else passed++;
    total++; if (job_ready !== 1'b1) $display("FAIL reset_job_ready: got %b want 1", job_ready); else passed++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [W-1:0] d; int lat, ni, n; bit tmo;
    fill_const(32'h3F800000, 32'h40000000);
    run_job(20, 32'h3F800000, 0, 0, d, lat, ni, tmo);
    total++; if (tmo) $display("FAIL basic_timeout: got timeout want result"); else passed++;
    total++; if (d !== 32'h42240000) $display("FAIL basic_data: got %h want 42240000", d); else passed++;
    total++; if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat); else passed++;
    total++; if (ni !== 3) $display("FAIL basic_issues: got %0d want 3", ni); else passed++;
    n = issue_cyc.size();
    total++;
    if (n < 3 || issue_cyc[n-1] - issue_cyc[n-2] !== 5 || issue_cyc[n-2] - issue_cyc[n-3] !== 5)
      $display("FAIL basic_issue_spacing: got %0d want 5", (n >= 2) ? issue_cyc[n-1] - issue_cyc[n-2] : -1);
    else passed++;
    consume();
  endtask

  task automatic test_masking();
    logic [W-1:0] d; int lat, ni; bit tmo;
    fill_const(32'h3F800000, 32'h40000000);
    run_job(20, 32'h3F800000, 1, 0, d, lat, ni, tmo);
    total++; if (d !== 32'h42240000) $display("FAIL mask_data: got %h want 42240000", d); else passed++;
    for (int k = 0; k < L; k++) begin
      total++;
      if (k < 2) begin
        if (lane(last_fa, k) !== 32'h3F800000 || lane(last_fb, k) !== 32'h40000000)
          $display("FAIL mask_active_lane%0d: got a=%h b=%h want 3f800000/40000000",
                   k, lane(last_fa, k), lane(last_fb, k));
        else passed++;
      end else begin
        if (lane(last_fa, k) !== '0 || lane(last_fb, k) !== '0)
          $display("FAIL mask_lane%0d: got a=%h b=%h want 0", k, lane(last_fa, k), lane(last_fb, k));
        else passed++;
      end
    end
    consume();
  endtask

  task automatic test_zero_len();
    logic [W-1:0] d; int lat, ni; bit tmo;
    run_job(0, 32'hC0400000, 0, 0, d, lat, ni, tmo);
    total++; if (d !== 32'hC0400000) $display("FAIL zero_data: got %h want c0400000", d); else passed++;
    total++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else passed++;
    total++; if (ni !== 0) $display("FAIL zero_issues: got %0d want 0", ni); else passed++;
    consume();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d, exp, c2; int lat, ni, len; bit tmo;
    fill_rand();
    len = $urandom_range(10, 30);
    exp = ref_dot(len, 32'h40400000);
    run_job(len, 32'h40400000, 0, 0, d, lat, ni, tmo);
    total++; if (d !== exp) $display("FAIL bp_data: got %h want %h", d, exp); else passed++;
    for (int i = 0; i < 10; i++) begin
      job_valid = 1'b1; job_len = '0; job_c = $urandom;
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_data !== exp || job_ready !== 1'b0)
        $display("FAIL bp_hold%0d: got v=%b d=%h jr=%b want v=1 d=%h jr=0", i, res_valid, res_data, job_ready, exp);
      else passed++;
    end
    job_valid = 1'b0;
    consume();
    total++; if (job_ready !== 1'b1) $display("FAIL bp_job_ready_after: got %b want 1", job_ready); else passed++;
    c2 = rand_val();
    run_job(0, c2, 0, 0, d, lat, ni, tmo);
    total++; if (lat !== 1 || d !== c2) $display("FAIL bp_next_job: got lat=%0d d=%h want 1/%h", lat, d, c2); else passed++;
    consume();
  endtask

  task automatic test_reset_mid_job();
    logic [W-1:0] d; int lat, ni; bit tmo;
    fill_const(32'h3F800000, 32'h40000000);
    run_job(20, 32'h3F800000, 0, 2, d, lat, ni, tmo);
    total++; if (ni !== 2 || busy !== 1'b1) $display("FAIL rmid_reach_wait: got issues=%0d busy=%b want 2/1", ni, busy); else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (fma_a !== '0 || fma_b !== '0 || fma_c !== '0 || res_data !== '0 ||
        fma_issue !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || elem_ready !== 1'b0)
      $display("FAIL rmid_outputs: got c=%h issue=%b busy=%b want all 0", fma_c, fma_issue, busy);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++; if (job_ready !== 1'b1) $display("FAIL rmid_job_ready: got %b want 1", job_ready); else passed++;
    fill_const(32'h3F800000, 32'h3F800000);
    run_job(9, 32'h00000000, 1, 0, d, lat, ni, tmo);
    total++; if (d !== 32'h41100000) $display("FAIL rmid_new_job: got %h want 41100000", d); else passed++;
    consume();
  endtask

  task automatic test_exact_multiple();
    logic [W-1:0] d, exp; int lat, ni; bit tmo;
    fill_rand();
    exp = ref_dot(18, 32'h3F000000);
    run_job(18, 32'h3F000000, 1, 0, d, lat, ni, tmo);
    total++; if (ni !== 2) $display("FAIL exact_issues: got %0d want 2", ni); else passed++;
    total++; if (d !== exp) $display("FAIL exact_data: got %h want %h", d, exp); else passed++;
    for (int k = 0; k < L; k++) begin
      total++;
      if (lane(last_fa, k) !== a_mem[9+k] || lane(last_fb, k) !== b_mem[9+k])
        $display("FAIL exact_lane%0d: got a=%h want %h", k, lane(last_fa, k), a_mem[9+k]);
      else passed++;
    end
    consume();
  endtask

  task automatic test_max_len();
    logic [W-1:0] d, exp; int lat, ni; bit tmo;
    fill_rand();
    exp = ref_dot(ML, 32'hBF800000);
    run_job(ML, 32'hBF800000, 1, 0, d, lat, ni, tmo);
    total++; if (ni !== 114) $display("FAIL max_issues: got %0d want 114", ni); else passed++;
    total++; if (d !== exp) $display("FAIL max_data: got %h want %h", d, exp); else passed++;
    total++; if (lat !== ref_lat(ML)) $display("FAIL max_latency: got %0d want %0d", lat, ref_lat(ML)); else passed++;
    for (int k = 0; k < L; k++) begin
      total++;
      if (k < 6) begin
        if (lane(last_fa, k) !== a_mem[1017+k]) $display("FAIL max_lane%0d: got %h want %h", k, lane(last_fa, k), a_mem[1017+k]);
        else passed++;
      end else begin
        if (lane(last_fa, k) !== '0 || lane(last_fb, k) !== '0) $display("FAIL max_lane%0d: got %h want 0", k, lane(last_fa, k));
        else passed++;
      end
    end
    consume();
  endtask

  task automatic test_random();
    logic [W-1:0] d, exp, c; int lat, ni, len; bit tmo;
    junk_elem = 1;
    for (int j = 0; j < 12; j++) begin
      fill_rand();
      len = $urandom_range(0, 50);
      c = rand_val();
      exp = ref_dot(len, c);
      run_job(len, c, 0, 0, d, lat, ni, tmo);
      total++;
      if (tmo || d !== exp || lat !== ref_lat(len) || ni !== (len + L - 1) / L)
        $display("FAIL random_job%0d: got d=%h lat=%0d issues=%0d want d=%h lat=%0d issues=%0d (len=%0d)",
                 j, d, lat, ni, exp, ref_lat(len), (len + L - 1) / L, len);
      else passed++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
    junk_elem = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masking();
    test_zero_len();
    test_backpressure();
    test_reset_mid_job();
    test_exact_multiple();
    test_max_len();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1);
  end

endmodule
